// File: rtl/axis_play_gate_if.sv
// AXI4-Stream bundle carrying DMA read beats into the playback gate.
interface axis_play_gate_if #(
   parameter int unsigned DATA_W = 256
) ();
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_play_gate.sv
// Playback gate: buffers DMA stream beats, primes, then feeds one beat per DAC
// request with zero-fill on underflow; also checks frame length and counts status.
module axis_play_gate #(
   parameter int unsigned DATA_W     = 256,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PRIME_LVL  = 8
) (
   input  logic                          axi_aclk,
   input  logic                          axi_rstb,
   axis_play_gate_if.slave               s_axis,
   input  logic                          play_en,
   input  logic [26:0]                   frame_beats,
   input  logic                          dac_req,
   output logic [DATA_W-1:0]             dac_data,
   output logic                          dac_valid,
   output logic [15:0]                   underflow_cnt,
   output logic [15:0]                   frame_cnt,
   output logic                          frame_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [1:0]                    state
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned CNT_W = 27;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_PLAY  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   dac_data_q, dac_data_d;
   logic                dac_valid_q, dac_valid_d;
   logic [15:0]         uf_cnt_q, uf_cnt_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic                frame_err_q, frame_err_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

   logic                tready_c;
   logic                active_c;
   logic                push_c;
   logic                pop_c;
   logic                tkeep_unused;

   // tkeep carries no information for this datapath
   assign tkeep_unused = ^s_axis.tkeep;

   // Ready comes from the registered level, so a full FIFO refuses even with a pop
   assign tready_c = (state_q == ST_IDLE) || (level_q < LVL_W'(FIFO_DEPTH));
   // Anything accepted in the cycle play_en drops is discarded by the flush
   assign active_c = (state_q != ST_IDLE) && play_en;
   assign push_c   = active_c && s_axis.tvalid && tready_c;
   assign pop_c    = active_c && (state_q == ST_PLAY) && dac_req && (level_q != '0);

   // State register
   always_ff @(posedge axi_aclk or negedge axi_rstb) begin
      if (!axi_rstb) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // Next-state: prime until the registered level hits the threshold
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (play_en) state_d = ST_PRIME;
         ST_PRIME: begin
            if (!play_en)                           state_d = ST_IDLE;
            else if (level_q >= LVL_W'(PRIME_LVL))  state_d = ST_PLAY;
         end
         ST_PLAY:  if (!play_en) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FIFO storage, write side only; not reset since level qualifies contents
   always_ff @(posedge axi_aclk) begin
      if (push_c) mem_q[wr_ptr_q] <= s_axis.tdata;
   end

   // Datapath next values: FIFO pointers, DAC output, framing and counters
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      dac_data_d  = dac_data_q;
      dac_valid_d = dac_valid_q;
      uf_cnt_d    = uf_cnt_q;
      frame_cnt_d = frame_cnt_q;
      frame_err_d = frame_err_q;
      beat_cnt_d  = beat_cnt_q;

      if (!active_c) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         dac_data_d  = '0;
         dac_valid_d = 1'b0;
         frame_err_d = 1'b0;
         beat_cnt_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);

         if (state_q == ST_PRIME) begin
            dac_data_d  = '0;
            dac_valid_d = 1'b0;
         end else if ((state_q == ST_PLAY) && dac_req) begin
            if (pop_c) begin
               dac_data_d  = mem_q[rd_ptr_q];
               dac_valid_d = 1'b1;
            end else begin
               dac_data_d  = '0;
               dac_valid_d = 1'b0;
               if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
            end
         end

         if (push_c) begin
            if (frame_beats == '0) begin
               if (s_axis.tlast) begin
                  beat_cnt_d  = '0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  beat_cnt_d  = beat_cnt_q + CNT_W'(1);
               end
            end else if (beat_cnt_q >= frame_beats - CNT_W'(1)) begin
               beat_cnt_d = '0;
               if (s_axis.tlast) frame_cnt_d = frame_cnt_q + 16'd1;
               else              frame_err_d = 1'b1;
            end else if (s_axis.tlast) begin
               beat_cnt_d  = '0;
               frame_err_d = 1'b1;
            end else begin
               beat_cnt_d  = beat_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge axi_aclk or negedge axi_rstb) begin
      if (!axi_rstb) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         dac_data_q  <= '0;
         dac_valid_q <= 1'b0;
         uf_cnt_q    <= '0;
         frame_cnt_q <= '0;
         frame_err_q <= 1'b0;
         beat_cnt_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         uf_cnt_q    <= uf_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         frame_err_q <= frame_err_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign s_axis.tready  = tready_c;
   assign dac_data       = dac_data_q;
   assign dac_valid      = dac_valid_q;
   assign underflow_cnt  = uf_cnt_q;
   assign frame_cnt      = frame_cnt_q;
   assign frame_err      = frame_err_q;
   assign fifo_level     = level_q;
   assign state          = state_q;

endmodule

// File: tb/tb_axis_play_gate.sv
// Bench for axis_play_gate: directed scenarios plus randomized traffic against a queue model.
module tb_axis_play_gate;

   localparam int unsigned DW    = 256;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PRIME = 8;

   logic            axi_aclk = 1'b0;
   logic            axi_rstb;
   logic            play_en;
   logic [26:0]     frame_beats;
   logic            dac_req;
   logic [DW-1:0]   dac_data;
   logic            dac_valid;
   logic [15:0]     underflow_cnt;
   logic [15:0]     frame_cnt;
   logic            frame_err;
   logic [4:0]      fifo_level;
   logic [1:0]      state;

   axis_play_gate_if #(.DATA_W(DW)) axis ();

   axis_play_gate #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PRIME_LVL(PRIME)) dut (
      .axi_aclk      (axi_aclk),
      .axi_rstb      (axi_rstb),
      .s_axis        (axis),
      .play_en       (play_en),
      .frame_beats   (frame_beats),
      .dac_req       (dac_req),
      .dac_data      (dac_data),
      .dac_valid     (dac_valid),
      .underflow_cnt (underflow_cnt),
      .frame_cnt     (frame_cnt),
      .frame_err     (frame_err),
      .fifo_level    (fifo_level),
      .state         (state)
   );

   always #5 axi_aclk = ~axi_aclk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: FIFO as a queue, frame tracked as beats seen so far
   int            m_state;
   logic [DW-1:0] m_q [$];
   logic [DW-1:0] m_data;
   logic          m_valid;
   int            m_uf;
   int            m_fc;
   logic          m_ferr;
   int            m_beats;

   function automatic logic [DW-1:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_state = 0; m_q.delete(); m_data = '0; m_valid = 1'b0;
      m_uf = 0; m_fc = 0; m_ferr = 1'b0; m_beats = 0;
   endtask

   // One clock: apply current inputs, advance the model, return #1 after the edge
   task automatic step();
      logic [DW-1:0] in_data;
      bit in_valid, in_last, in_play, in_req, rdy, acc;
      int in_fb, lvl;
      in_data = axis.tdata; in_valid = axis.tvalid; in_last = axis.tlast;
      in_play = play_en; in_req = dac_req; in_fb = int'(frame_beats);
      @(posedge axi_aclk);
      #1;
      lvl = m_q.size();
      rdy = (m_state == 0) || (lvl < DEPTH);
      acc = in_valid && rdy;
      if (m_state == 0 || !in_play) begin
         m_q.delete(); m_data = '0; m_valid = 1'b0; m_beats = 0; m_ferr = 1'b0;
         m_state = in_play && m_state == 0 ? 1 : 0;
      end else begin
         if (acc) begin
            m_beats++;
            if (in_fb == 0) begin
               if (in_last) begin m_fc = (m_fc + 1) & 16'hFFFF; m_beats = 0; end
            end else if (in_last || m_beats == in_fb) begin
               if (in_last && m_beats == in_fb) m_fc = (m_fc + 1) & 16'hFFFF;
               else                             m_ferr = 1'b1;
               m_beats = 0;
            end
         end
         if (m_state == 2 && in_req) begin
            if (lvl > 0) begin m_data = m_q.pop_front(); m_valid = 1'b1; end
            else begin m_data = '0; m_valid = 1'b0; if (m_uf < 65535) m_uf++; end
         end
         if (acc) m_q.push_back(in_data);
         if (m_state == 1 && lvl >= PRIME) m_state = 2;
      end
   endtask

   task automatic test_reset();
      axi_rstb = 1'b0; play_en = 1'b0; frame_beats = '0; dac_req = 1'b0;
      axis.tdata = '0; axis.tkeep = '1; axis.tlast = 1'b0; axis.tvalid = 1'b0;
      model_reset();
      #23;
      n_vec++; if (state !== 2'd0) begin n_miss++; $display("FAIL reset_state got %0d exp 0", state); end
      n_vec++; if (fifo_level !== 5'd0) begin n_miss++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
      n_vec++; if ({dac_valid, frame_err} !== 2'b00) begin n_miss++; $display("FAIL reset_flags got %b%b exp 00", dac_valid, frame_err); end
      n_vec++; if (dac_data !== '0) begin n_miss++; $display("FAIL reset_data got %0h exp 0", dac_data); end
      n_vec++; if ({underflow_cnt, frame_cnt} !== 32'd0) begin n_miss++; $display("FAIL reset_cnts got %0h/%0h exp 0/0", underflow_cnt, frame_cnt); end
      @(posedge axi_aclk); #1;
      axi_rstb = 1'b1;
      n_vec++; if (axis.tready !== 1'b1) begin n_miss++; $display("FAIL idle_tready got %b exp 1", axis.tready); end
   endtask

   task automatic test_prime();
      play_en = 1'b1; frame_beats = '0; dac_req = 1'b0; axis.tvalid = 1'b0;
      step();
      n_vec++; if (state !== 2'd1) begin n_miss++; $display("FAIL prime_enter got %0d exp 1", state); end
      for (int i = 1; i <= 8; i++) begin
         axis.tdata = DW'(i); axis.tvalid = 1'b1; axis.tlast = 1'b0;
         step();
         n_vec++; if (fifo_level !== 5'(i) || state !== 2'd1) begin n_miss++; $display("FAIL prime_fill level %0d state %0d exp %0d/1", fifo_level, state, i); end
      end
      axis.tvalid = 1'b0;
      step();
      n_vec++; if (state !== 2'd2 || fifo_level !== 5'd8 || dac_valid !== 1'b0) begin n_miss++; $display("FAIL prime_to_play state %0d level %0d valid %b exp 2/8/0", state, fifo_level, dac_valid); end
   endtask

   task automatic test_playback();
      dac_req = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         n_vec++; if (dac_data !== DW'(i) || dac_valid !== 1'b1 || underflow_cnt !== 16'd0) begin n_miss++; $display("FAIL play_beat%0d data %0h valid %b uf %0d exp %0d/1/0", i, dac_data, dac_valid, underflow_cnt, i); end
      end
      step();
      n_vec++; if (dac_data !== '0 || dac_valid !== 1'b0 || underflow_cnt !== 16'd1) begin n_miss++; $display("FAIL play_underflow data %0h valid %b uf %0d exp 0/0/1", dac_data, dac_valid, underflow_cnt); end
      dac_req = 1'b0;
   endtask

   task automatic test_framing();
      int lens [4] = '{4, 4, 3, 4};
      int exp_fc [4] = '{1, 2, 2, 3};
      bit exp_err [4] = '{0, 0, 1, 1};
      play_en = 1'b0; step();
      play_en = 1'b1; frame_beats = 27'd4; step();
      for (int f = 0; f < 4; f++) begin
         for (int b = 0; b < lens[f]; b++) begin
            axis.tdata = rand_beat(); axis.tvalid = 1'b1; axis.tlast = (b == lens[f] - 1);
            step();
         end
         n_vec++; if (frame_cnt !== 16'(exp_fc[f]) || frame_err !== exp_err[f]) begin n_miss++; $display("FAIL frame%0d fc %0d err %b exp %0d/%b", f, frame_cnt, frame_err, exp_fc[f], exp_err[f]); end
      end
      axis.tvalid = 1'b0; axis.tlast = 1'b0; play_en = 1'b0; step();
      n_vec++; if (frame_err !== 1'b0 || frame_cnt !== 16'd3) begin n_miss++; $display("FAIL frame_idle err %b fc %0d exp 0/3", frame_err, frame_cnt); end
      play_en = 1'b1; step();
      for (int b = 0; b < 5; b++) begin
         axis.tdata = rand_beat(); axis.tvalid = 1'b1; axis.tlast = (b == 4);
         step();
         n_vec++; if (frame_err !== (b >= 3)) begin n_miss++; $display("FAIL long_frame beat%0d err %b exp %b", b, frame_err, b >= 3); end
      end
      axis.tvalid = 1'b0; axis.tlast = 1'b0;
   endtask

   task automatic test_backpressure();
      int acc = 0;
      logic [DW-1:0] first = '0;
      play_en = 1'b0; step();
      play_en = 1'b1; frame_beats = 27'd4; dac_req = 1'b0; step();
      axis.tvalid = 1'b1; axis.tlast = 1'b0;
      for (int c = 0; c < 24; c++) begin
         axis.tdata = rand_beat();
         if (axis.tready) begin if (acc == 0) first = axis.tdata; acc++; end
         step();
      end
      n_vec++; if (acc != 16 || fifo_level !== 5'd16 || axis.tready !== 1'b0) begin n_miss++; $display("FAIL bp_full acc %0d level %0d tready %b exp 16/16/0", acc, fifo_level, axis.tready); end
      n_vec++; if (frame_err !== 1'b1 || state !== 2'd2) begin n_miss++; $display("FAIL bp_status err %b state %0d exp 1/2", frame_err, state); end
      dac_req = 1'b1; step();
      n_vec++; if (dac_data !== first || dac_valid !== 1'b1 || fifo_level !== 5'd15) begin n_miss++; $display("FAIL bp_pop data %0h valid %b level %0d exp %0h/1/15", dac_data, dac_valid, fifo_level, first); end
      dac_req = 1'b0; step();
      n_vec++; if (fifo_level !== 5'd16 || axis.tready !== 1'b0) begin n_miss++; $display("FAIL bp_refill level %0d tready %b exp 16/0", fifo_level, axis.tready); end
      axis.tvalid = 1'b0;
   endtask

   task automatic test_stop_flush();
      dac_req = 1'b1; axis.tvalid = 1'b0;
      repeat (6) step();
      n_vec++; if (fifo_level !== 5'd10 || state !== 2'd2) begin n_miss++; $display("FAIL stop_pre level %0d state %0d exp 10/2", fifo_level, state); end
      play_en = 1'b0; axis.tvalid = 1'b1; axis.tdata = rand_beat();
      step();
      n_vec++; if (state !== 2'd0 || fifo_level !== 5'd0 || axis.tready !== 1'b1) begin n_miss++; $display("FAIL stop_flush state %0d level %0d tready %b exp 0/0/1", state, fifo_level, axis.tready); end
      n_vec++; if (frame_err !== 1'b0 || dac_valid !== 1'b0 || dac_data !== '0) begin n_miss++; $display("FAIL stop_outputs err %b valid %b data %0h exp 0/0/0", frame_err, dac_valid, dac_data); end
      n_vec++; if (underflow_cnt !== 16'd1 || frame_cnt !== 16'd3) begin n_miss++; $display("FAIL stop_counters uf %0d fc %0d exp 1/3", underflow_cnt, frame_cnt); end
      dac_req = 1'b0; axis.tvalid = 1'b0;
   endtask

   task automatic test_random();
      frame_beats = 27'd3;
      for (int c = 0; c < 3000; c++) begin
         play_en = ($urandom_range(0, 99) != 0);
         axis.tvalid = $urandom_range(0, 1) == 1;
         axis.tlast = ($urandom_range(0, 3) == 0);
         axis.tdata = rand_beat();
         dac_req = ($urandom_range(0, 2) != 0);
         step();
         n_vec++; if (state !== 2'(m_state) || fifo_level !== 5'(m_q.size()) || frame_err !== m_ferr) begin n_miss++; $display("FAIL rand_ctrl c%0d state %0d level %0d err %b exp %0d/%0d/%b", c, state, fifo_level, frame_err, m_state, m_q.size(), m_ferr); end
         n_vec++; if (dac_data !== m_data || dac_valid !== m_valid) begin n_miss++; $display("FAIL rand_dac c%0d data %0h valid %b exp %0h/%b", c, dac_data, dac_valid, m_data, m_valid); end
         n_vec++; if (underflow_cnt !== 16'(m_uf) || frame_cnt !== 16'(m_fc)) begin n_miss++; $display("FAIL rand_cnt c%0d uf %0d fc %0d exp %0d/%0d", c, underflow_cnt, frame_cnt, m_uf, m_fc); end
      end
      axis.tvalid = 1'b0; axis.tlast = 1'b0; dac_req = 1'b0;
   endtask

   task automatic test_saturation();
      play_en = 1'b0; step();
      play_en = 1'b1; step();
      axis.tvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin axis.tdata = rand_beat(); step(); end
      axis.tvalid = 1'b0; step();
      n_vec++; if (state !== 2'd2) begin n_miss++; $display("FAIL sat_play state %0d exp 2", state); end
      dac_req = 1'b1;
      repeat (8 + 65540) step();
      n_vec++; if (underflow_cnt !== 16'hFFFF || underflow_cnt !== 16'(m_uf)) begin n_miss++; $display("FAIL sat_uf got %0h exp ffff", underflow_cnt); end
      n_vec++; if (dac_valid !== 1'b0 || state !== 2'd2) begin n_miss++; $display("FAIL sat_state valid %b state %0d exp 0/2", dac_valid, state); end
      dac_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      axis.tvalid = 1'b1;
      repeat (2) begin axis.tdata = rand_beat(); step(); end
      axis.tvalid = 1'b0; dac_req = 1'b1; step();
      n_vec++; if (dac_valid !== 1'b1 || dac_data !== m_data) begin n_miss++; $display("FAIL rst_pre valid %b data %0h exp 1/%0h", dac_valid, dac_data, m_data); end
      #2 axi_rstb = 1'b0;
      #1;
      n_vec++; if (state !== 2'd0 || fifo_level !== 5'd0 || dac_valid !== 1'b0 || frame_err !== 1'b0) begin n_miss++; $display("FAIL rst_mid_ctrl state %0d level %0d valid %b err %b exp 0/0/0/0", state, fifo_level, dac_valid, frame_err); end
      n_vec++; if (dac_data !== '0 || underflow_cnt !== 16'd0 || frame_cnt !== 16'd0) begin n_miss++; $display("FAIL rst_mid_data data %0h uf %0h fc %0h exp 0/0/0", dac_data, underflow_cnt, frame_cnt); end
      model_reset();
      play_en = 1'b0; dac_req = 1'b0;
      @(posedge axi_aclk); #1;
      axi_rstb = 1'b1;
   endtask

   initial begin
      test_reset();
      test_prime();
      test_playback();
      test_framing();
      test_backpressure();
      test_stop_flush();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
